// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, counter width and bubble encoding.
package hazard_stall_unit_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam int CNT_W = 32;

   // Bubble loaded by the flush paths: sll $0,$0,0.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_stall_unit_perf_counter.sv
// Saturating event counter with synchronous clear; clr beats inc, rst beats both.
module perf_counter
   import hazard_stall_unit_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: freezes, stalls and flushes pipeline registers and
// counts stall cycles and taken-branch flushes.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IFID_RS,
   input  logic [4:0]       IFID_RT,
   input  logic [4:0]       IDEX_RD,
   input  logic             IDEX_MemRead,
   input  logic             BRANCH_TAKEN,
   input  logic             ICACHE_STALL,
   input  logic             DCACHE_STALL,
   input  logic             CNT_CLR,
   output logic             PC_WRITE,
   output logic             IFID_WRITE,
   output logic             IDEX_WRITE,
   output logic             EXMEM_WRITE,
   output logic             MEMWB_WRITE,
   output logic             IFID_FLUSH,
   output logic             IDEX_FLUSH,
   output logic             MEM_WAIT_ST,
   output logic [CNT_W-1:0] STALL_CYCLES,
   output logic [CNT_W-1:0] FLUSH_EVENTS
);

   hz_state_t state;
   hz_state_t state_next;
   logic      load_use;
   logic      flush_win;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = IDEX_MemRead && (IDEX_RD != 5'd0) &&
                     ((IDEX_RD == IFID_RS) || (IDEX_RD == IFID_RT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      PC_WRITE    = 1'b1;
      IFID_WRITE  = 1'b1;
      IDEX_WRITE  = 1'b1;
      EXMEM_WRITE = 1'b1;
      MEMWB_WRITE = 1'b1;
      IFID_FLUSH  = 1'b0;
      IDEX_FLUSH  = 1'b0;
      flush_win   = 1'b0;

      case (state)
         IDLE:     if (DCACHE_STALL) state_next = MEM_WAIT;
         MEM_WAIT: if (!DCACHE_STALL) state_next = IDLE;
         default:  state_next = IDLE;
      endcase

      if (!rst) begin
         if (DCACHE_STALL) begin
            // Full freeze; a taken branch stays in EX and is re-evaluated afterwards.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            MEMWB_WRITE = 1'b0;
         end else if (BRANCH_TAKEN) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
            flush_win  = 1'b1;
         end else if (load_use) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_FLUSH = 1'b1;
         end else if (ICACHE_STALL) begin
            PC_WRITE   = 1'b0;
            IFID_FLUSH = 1'b1;
         end
      end
   end

   assign MEM_WAIT_ST = (state == MEM_WAIT);

   perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (CNT_CLR),
      .inc   (!PC_WRITE),
      .count (STALL_CYCLES)
   );

   perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (CNT_CLR),
      .inc   (flush_win),
      .count (FLUSH_EVENTS)
   );

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the ports IFID_RS and IFID_RT, input, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have the ports IDEX_RD (input, 5 bits) and IDEX_MemRead (input, 1 bit): destination register and load flag of the instruction in EX.
REQ-005 The block SHALL have the port BRANCH_TAKEN, input, 1 bit: branch or jump resolved taken in EX.
REQ-006 The block SHALL have the ports ICACHE_STALL and DCACHE_STALL, input, 1 bit each: instruction-memory and data-memory busy.
REQ-007 The block SHALL have the port CNT_CLR, input, 1 bit: synchronous clear of the performance counters.
REQ-008 The block SHALL have the ports PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE and MEMWB_WRITE, output, 1 bit each: pipeline-register enables.
REQ-009 The block SHALL have the ports IFID_FLUSH and IDEX_FLUSH, output, 1 bit each: load a NOP bubble into that pipeline register.
REQ-010 The block SHALL have the port MEM_WAIT_ST, output, 1 bit: FSM is in the MEM_WAIT state.
REQ-011 The block SHALL have the ports STALL_CYCLES and FLUSH_EVENTS, output, 32 bits each: performance counters.

Function
REQ-012 The FSM SHALL have two states: IDLE and MEM_WAIT.
REQ-013 IDLE SHALL go to MEM_WAIT when DCACHE_STALL=1.
REQ-014 MEM_WAIT SHALL stay in MEM_WAIT while DCACHE_STALL=1 and return to IDLE in the first cycle it samples DCACHE_STALL=0.
REQ-015 Control outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency.
REQ-016 Defaults SHALL be: all *_WRITE=1, all *_FLUSH=0.
REQ-017 Priority, highest first: DCACHE_STALL, BRANCH_TAKEN, load-use, ICACHE_STALL; only the highest active condition SHALL drive the outputs.
REQ-018 DCACHE_STALL=1, in either state: all five *_WRITE=0 and both flushes=0 (full freeze); a concurrent BRANCH_TAKEN SHALL be ignored, since the branch stays held in EX and is re-evaluated after the freeze.
REQ-019 BRANCH_TAKEN=1 without DCACHE_STALL: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1.
REQ-020 Load-use condition = IDEX_MemRead AND IDEX_RD!=0 AND (IDEX_RD==IFID_RS OR IDEX_RD==IFID_RT).
REQ-021 When load-use is the winning condition: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1, for exactly one cycle; it SHALL self-clear because the bubble clears IDEX_MemRead.
REQ-022 Register x0 SHALL never cause a stall.
REQ-023 When ICACHE_STALL is the winning condition: PC_WRITE=0, IFID_FLUSH=1; EX, MEM and WB stages SHALL advance.
REQ-024 STALL_CYCLES SHALL increment by 1 in every cycle in which PC_WRITE=0.
REQ-025 FLUSH_EVENTS SHALL increment by 1 in every cycle in which BRANCH_TAKEN wins (REQ-019).
REQ-026 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-027 CNT_CLR=1 SHALL zero both counters on the next edge; CNT_CLR SHALL take priority over an increment in the same cycle.

Reset
REQ-028 rst=1 at a rising edge SHALL set the state to IDLE and both counters to 0.
REQ-029 While rst=1, control outputs SHALL take the IDLE defaults regardless of the other inputs.
REQ-030 Reset SHALL take priority over CNT_CLR.
REQ-031 Reset during MEM_WAIT SHALL abandon the wait; after reset, the state SHALL re-enter MEM_WAIT only if DCACHE_STALL is still 1.

Structure
REQ-032 The state encoding (IDLE=1'b0, MEM_WAIT=1'b1) and the counter width localparam (32) SHALL live in the shared pipeline package, together with the NOP encoding used by the flush paths.
REQ-033 The single sub-module perf_counter SHALL be instantiated twice: a 32-bit saturating counter with inc, clr, clk and rst ports.
REQ-034 Register comparisons SHALL be flat logic, with no sub-module.

Verification
REQ-035 The bench SHALL drive IDEX_MemRead=1, IDEX_RD=5, IFID_RS=5 and require: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1 for 1 cycle; STALL_CYCLES 0 to 1.
REQ-036 The bench SHALL repeat REQ-035 with IDEX_RD=0 and IFID_RS=0 and require: no stall; STALL_CYCLES unchanged.
REQ-037 The bench SHALL drive DCACHE_STALL=1 for 3 cycles together with BRANCH_TAKEN=1 and require: full freeze for 3 cycles, MEM_WAIT_ST=1 from cycle 2, no flush, FLUSH_EVENTS=0; then, on release with BRANCH_TAKEN=1, both flushes=1 and FLUSH_EVENTS=1.
REQ-038 The bench SHALL drive BRANCH_TAKEN=1 and load-use together and require: only the flush (IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1), no stall.
REQ-039 The bench SHALL preload STALL_CYCLES to 32'hFFFFFFFE via stall cycles (or force it), apply 3 stall cycles and require 32'hFFFFFFFF, held; then CNT_CLR=1 together with a stall SHALL give 0.
REQ-040 The bench SHALL assert rst in cycle 2 of MEM_WAIT while DCACHE_STALL=1 and require: state=IDLE and counters=0 at the reset edge; MEM_WAIT re-entered 1 cycle after rst deasserts.
